seg_scan_capture: RTL and testbench
===================================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Purpose: receive end of the 4-digit multiplexed display scan (active-low one-hot anode select plus 4-bit digit nibble); rebuilds the 16-bit word and checks scan sequence integrity; used for loopback and self-test.

Interface
REQ-001 Parameter LOCK_FRAMES, default 2, meaning consecutive good frames needed to assert locked (range 1-15).
REQ-002 clk1khz  input  1  sampling clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 AN  input  4  anode select, active-low one-hot; bit k low selects digit k.
REQ-005 smallbin  input  4  nibble for the selected digit.
REQ-006 word  output  16  last complete frame; digit k in bits [4k+3:4k].
REQ-007 word_valid  output  1  one-cycle pulse when word updates.
REQ-008 locked  output  1  LOCK_FRAMES consecutive error-free frames seen.
REQ-009 seq_err  output  1  one-cycle pulse on digit-order violation.
REQ-010 illegal_an  output  1  one-cycle pulse on a malformed AN pattern.
REQ-011 frame_cnt  output  8  count of completed frames, saturating at 255.

Function
REQ-012 The block SHALL sample AN/smallbin on every rising clk1khz edge and register all outputs on that same edge, giving a latency of one edge.
REQ-013 AN decode SHALL be: 1110->0, 1101->1, 1011->2, 0111->3, 1111->blank, any other value->illegal.
REQ-014 States SHALL be HUNT and COLLECT; COLLECT holds last index L (2 bits) and a 16-bit shadow register.
REQ-015 Blank SHALL cause no state, shadow or output change in either state.
REQ-016 In HUNT, index 0 SHALL write the nibble to shadow[3:0], set L=0 and go to COLLECT; indices 1-3 SHALL be ignored without raising seq_err.
REQ-017 In COLLECT, index==L (hold) SHALL overwrite shadow digit L with the current nibble and SHALL NOT advance state or pulse anything.
REQ-018 In COLLECT, index==(L+1) mod 4 SHALL write that shadow digit and set L=index.
REQ-019 The transition L=2 to index 3 SHALL complete a frame: word takes the shadow value with digit 3 replaced by the current nibble, word_valid pulses, frame_cnt increments (saturating), and the good-frame counter increments (saturating at 15).
REQ-020 Holding on digit 3 SHALL NOT produce a further word_valid; index 0 after L=3 SHALL start the next frame with no error.
REQ-021 Any other index in COLLECT SHALL pulse seq_err and clear the good-frame counter and locked; if that index is 0 it SHALL start a new frame (L=0, shadow[3:0] written), otherwise the block SHALL go to HUNT.
REQ-022 An illegal AN in any state SHALL pulse illegal_an, clear the good-frame counter and locked, go to HUNT, and SHALL NOT raise seq_err.
REQ-023 locked SHALL assert on the edge where the good-frame counter reaches LOCK_FRAMES, and SHALL remain set until an error or reset.
REQ-024 word SHALL keep its last value across errors and HUNT; only a completed frame SHALL change it.
REQ-025 If a frame completes on the same edge as the count reaches LOCK_FRAMES, word_valid and locked SHALL both assert on that edge.

Reset
REQ-026 When rst is high at an edge: state=HUNT, L=0, shadow=0, word=16'h0000, word_valid=0, locked=0, seq_err=0, illegal_an=0, frame_cnt=0, good counter=0; sampled inputs on that edge SHALL be discarded.
REQ-027 A reset mid-frame SHALL discard the partial shadow, and the first frame after reset SHALL start only at index 0.

Verification
REQ-028 After reset, scan AN=1110/1101/1011/0111 with nibbles 4,3,2,1 -> word=16'h1234, word_valid for exactly one cycle, frame_cnt=1, locked=0.
REQ-029 Two consecutive clean frames of 16'hBEEF, LOCK_FRAMES=2 -> locked rises on the edge of the second word_valid; frame_cnt=2.
REQ-030 Digits 0,1 then AN=0111 (skips 2) -> seq_err pulse, state HUNT, locked cleared, word unchanged; a following clean frame 16'hA5A5 -> word=16'hA5A5.
REQ-031 AN=1100 mid-frame -> illegal_an pulse, no seq_err, no word_valid until a full 0..3 sequence; AN=1111 inserted between digits -> ignored, frame completes normally.
REQ-032 Each digit held 3 cycles, nibble changing during the hold on digit 1 (5 then 6), digits 0,2,3 = 0,0,0 -> word=16'h0060, single word_valid; 300 frames -> frame_cnt stays at 255.
REQ-033 rst asserted after digits 0,1 -> all outputs zero; resuming with digits 2,3 -> no word_valid and no seq_err.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Rebuilds the 16-bit word from a 4-digit multiplexed scan (active-low one-hot AN) and checks digit order.
// One-edge latency from sampled AN/smallbin to every registered output; no backpressure, a sample is taken every edge.
module seg_scan_capture #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk1khz,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [3:0]  smallbin,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        locked,
  output logic        seq_err,
  output logic        illegal_an,
  output logic [7:0]  frame_cnt
);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t      state;
  logic [1:0]  last_idx;
  logic [15:0] shadow;
  logic [3:0]  good_cnt;

  logic [1:0]  idx;
  logic        blank;
  logic        illegal;
  logic [3:0]  good_nxt;

  always_comb begin
    idx     = 2'd0;
    blank   = 1'b0;
    illegal = 1'b0;
    unique case (AN)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      4'b1111: blank = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  assign good_nxt = (good_cnt == 4'd15) ? good_cnt : good_cnt + 4'd1;

  always_ff @(posedge clk1khz) begin
    if (rst) begin
      state      <= HUNT;
      last_idx   <= 2'd0;
      shadow     <= 16'h0000;
      good_cnt   <= 4'd0;
      word       <= 16'h0000;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      illegal_an <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      word_valid <= 1'b0;
      seq_err    <= 1'b0;
      illegal_an <= 1'b0;
      if (illegal) begin
        illegal_an <= 1'b1;
        good_cnt   <= 4'd0;
        locked     <= 1'b0;
        state      <= HUNT;
      end else if (!blank) begin
        unique case (state)
          HUNT: begin
            // Only digit 0 can open a frame; stray digits while hunting are silent.
            if (idx == 2'd0) begin
              shadow[3:0] <= smallbin;
              last_idx    <= 2'd0;
              state       <= COLLECT;
            end
          end
          COLLECT: begin
            if (idx == last_idx) begin
              shadow[{idx, 2'b00} +: 4] <= smallbin;
            end else if (idx == last_idx + 2'd1) begin
              shadow[{idx, 2'b00} +: 4] <= smallbin;
              last_idx                  <= idx;
              if (idx == 2'd3) begin
                word       <= {smallbin, shadow[11:0]};
                word_valid <= 1'b1;
                frame_cnt  <= (frame_cnt == 8'd255) ? frame_cnt : frame_cnt + 8'd1;
                good_cnt   <= good_nxt;
                if (good_nxt >= 4'(LOCK_FRAMES)) locked <= 1'b1;
              end
            end else begin
              seq_err  <= 1'b1;
              good_cnt <= 4'd0;
              locked   <= 1'b0;
              // A misplaced digit 0 is treated as the start of a fresh frame.
              if (idx == 2'd0) begin
                shadow[3:0] <= smallbin;
                last_idx    <= 2'd0;
              end else begin
                state <= HUNT;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed scan vectors; expected output events are queued by the driver and checked by a separate monitor.
module tb_seg_scan_capture;

  logic        clk1khz;
  logic        rst;
  logic [3:0]  AN;
  logic [3:0]  smallbin;
  logic [15:0] word;
  logic        word_valid;
  logic        locked;
  logic        seq_err;
  logic        illegal_an;
  logic [7:0]  frame_cnt;

  typedef struct packed {
    logic [15:0] w;
    logic [7:0]  fc;
    logic        lk;
    logic        wv;
    logic        se;
    logic        ia;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;

  seg_scan_capture #(.LOCK_FRAMES(2)) dut (
    .clk1khz    (clk1khz),
    .rst        (rst),
    .AN         (AN),
    .smallbin   (smallbin),
    .word       (word),
    .word_valid (word_valid),
    .locked     (locked),
    .seq_err    (seq_err),
    .illegal_an (illegal_an),
    .frame_cnt  (frame_cnt)
  );

  initial begin
    clk1khz = 1'b0;
    forever #5 clk1khz = ~clk1khz;
  end

  // Monitor: every output pulse must match the oldest queued expectation.
  initial begin
    ev_t got;
    ev_t e;
    forever begin
      @(negedge clk1khz);
      if (word_valid === 1'b1 || seq_err === 1'b1 || illegal_an === 1'b1) begin
        got = {word, frame_cnt, locked, word_valid, seq_err, illegal_an};
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event word=%h fcnt=%0d lk=%b wv=%b se=%b ia=%b (none expected)",
                   got.w, got.fc, got.lk, got.wv, got.se, got.ia);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL event got word=%h fcnt=%0d lk=%b wv=%b se=%b ia=%b exp word=%h fcnt=%0d lk=%b wv=%b se=%b ia=%b",
                     got.w, got.fc, got.lk, got.wv, got.se, got.ia, e.w, e.fc, e.lk, e.wv, e.se, e.ia);
          end
        end
      end
    end
  end

  task automatic dig(input logic [3:0] an, input logic [3:0] nib);
    AN       = an;
    smallbin = nib;
    @(negedge clk1khz);
  endtask

  task automatic expect_ev(input logic [15:0] w, input logic [7:0] fc,
                           input logic lk, input logic wv, input logic se, input logic ia);
    ev_t e;
    e.w = w; e.fc = fc; e.lk = lk; e.wv = wv; e.se = se; e.ia = ia;
    q.push_back(e);
  endtask

  task automatic frame(input logic [15:0] w, input logic [7:0] fc, input logic lk);
    dig(4'b1110, w[3:0]);
    dig(4'b1101, w[7:4]);
    dig(4'b1011, w[11:8]);
    expect_ev(w, fc, lk, 1'b1, 1'b0, 1'b0);
    dig(4'b0111, w[15:12]);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    dig(4'b1110, 4'h9);
    dig(4'b1110, 4'h9);
    rst = 1'b0;
    check(name, {word, frame_cnt, locked, word_valid, seq_err, illegal_an},
          {16'h0000, 8'd0, 4'b0000});
  endtask

  initial begin
    rst      = 1'b1;
    AN       = 4'b1111;
    smallbin = 4'h0;
    @(negedge clk1khz);
    do_reset("reset_state");

    // Basic frame, then idle to show word_valid is a single cycle.
    frame(16'h1234, 8'd1, 1'b0);
    dig(4'b1111, 4'h0);
    dig(4'b1111, 4'h0);
    check("word_hold_1234", {16'h0, word}, {16'h0, 16'h1234});

    // Lock after two clean frames.
    do_reset("reset_before_lock");
    frame(16'hBEEF, 8'd1, 1'b0);
    frame(16'hBEEF, 8'd2, 1'b1);

    // Skipped digit 2: seq_err, lock lost, word kept.
    dig(4'b1110, 4'h5);
    dig(4'b1101, 4'hA);
    expect_ev(16'hBEEF, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    dig(4'b0111, 4'h0);
    frame(16'hA5A5, 8'd3, 1'b0);
    frame(16'hA5A5, 8'd4, 1'b1);

    // Illegal AN mid-frame; stray digits 2,3 in HUNT stay silent.
    dig(4'b1110, 4'h1);
    dig(4'b1101, 4'h2);
    expect_ev(16'hA5A5, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    dig(4'b1100, 4'h3);
    dig(4'b1011, 4'h3);
    dig(4'b0111, 4'h4);
    // Blanks between digits are ignored.
    dig(4'b1110, 4'h1);
    dig(4'b1111, 4'hF);
    dig(4'b1101, 4'h2);
    dig(4'b1111, 4'hF);
    dig(4'b1011, 4'h3);
    dig(4'b1111, 4'hF);
    expect_ev(16'h4321, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    dig(4'b0111, 4'h4);

    // Each digit held three cycles, digit 1 changes 5 -> 6 during its hold.
    for (int k = 0; k < 3; k++) dig(4'b1110, 4'h0);
    dig(4'b1101, 4'h5);
    dig(4'b1101, 4'h6);
    dig(4'b1101, 4'h6);
    for (int k = 0; k < 3; k++) dig(4'b1011, 4'h0);
    expect_ev(16'h0060, 8'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) dig(4'b0111, 4'h0);

    // frame_cnt saturates at 255.
    for (int i = 0; i < 300; i++)
      frame({4{4'(i)}}, 8'((7 + i > 255) ? 255 : 7 + i), 1'b1);
    check("frame_cnt_sat", {24'h0, frame_cnt}, {24'h0, 8'd255});

    // Reset mid-frame discards the partial frame.
    dig(4'b1110, 4'h7);
    dig(4'b1101, 4'h8);
    rst = 1'b1;
    dig(4'b1011, 4'h9);
    rst = 1'b0;
    check("mid_reset_outputs", {word, frame_cnt, locked, word_valid, seq_err, illegal_an},
          {16'h0000, 8'd0, 4'b0000});
    dig(4'b1011, 4'h9);
    dig(4'b0111, 4'h9);
    dig(4'b1111, 4'h0);
    check("after_reset_resume", {8'h0, word, frame_cnt}, {8'h0, 16'h0000, 8'd0});
    frame(16'h1234, 8'd1, 1'b0);

    // Misplaced digit 0 restarts the frame with seq_err.
    dig(4'b1110, 4'h7);
    dig(4'b1101, 4'h8);
    expect_ev(16'h1234, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    dig(4'b1110, 4'h1);
    dig(4'b1101, 4'h2);
    dig(4'b1011, 4'h3);
    expect_ev(16'h4321, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    dig(4'b0111, 4'h4);

    for (int k = 0; k < 3; k++) dig(4'b1111, 4'h0);
    check("pending_events", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
